dsc_mul_nin: RTL and testbench

- Parametrised deterministic stochastic-computing (DSC) multiplier for NUM_INPUTS unsigned operands of SNG_WIDTH bits each.
- Each operand drives one digit of a chained clock-division stream generator. The per-cycle product bit is the AND of all operand streams, and an output counter accumulates it, so the result is the exact integer product.
- Adds start/busy/done handshake, en stall, and early termination once the most-significant stream is known to be zero for the rest of the run.
- Sits between binary operand registers and downstream accumulation logic.

---
 rtl/dsc_pkg.sv | 19 +
 rtl/dsc_min_sort.sv | 32 +++
 rtl/dsc_mul_nin.sv | 95 +++++++++
 tb/tb_dsc_mul_nin.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/dsc_pkg.sv
// Shared types and constants for the deterministic stochastic-computing blocks.
package dsc_pkg;

  localparam int DSC_SNG_WIDTH  = 8;
  localparam int DSC_NUM_INPUTS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } dsc_state_e;

  // Total width of the chained digit counter (one digit per operand).
  function automatic int cnt_width(input int sng_width, input int num_inputs);
    return sng_width * num_inputs;
  endfunction

endpackage

// File: rtl/dsc_min_sort.sv
// Moves the smallest operand into the top slot (N-1). The operand it replaces
// goes into the minimum's old slot; every other slot is left as it was.
// A top operand that ties the minimum stays where it is.
module dsc_min_sort #(
  parameter int W = 8,
  parameter int N = 4
) (
  input  logic [N-1:0][W-1:0] in_vec,
  output logic [N-1:0][W-1:0] out_vec
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [W-1:0]  mn;
  logic [IW-1:0] idx;

  // Find the minimum (ties keep the top), then swap it with the top slot.
  always_comb begin
    mn  = in_vec[N-1];
    idx = IW'(N-1);
    for (int k = 0; k < N-1; k++) begin
      if (in_vec[k] < mn) begin
        mn  = in_vec[k];
        idx = IW'(k);
      end
    end
    out_vec      = in_vec;
    out_vec[idx] = in_vec[N-1];
    out_vec[N-1] = mn;
  end

endmodule

// File: rtl/dsc_mul_nin.sv
// N-input deterministic stochastic-computing multiplier.
// Each operand is compared against one digit of a chained clock-division
// counter. The AND of the stream bits is accumulated into z, which gives the
// exact product.
// Define DSC_MUL_SORT_EN to put the smallest operand in the top slot. This
// shortens the run, and any zero operand then ends it at once.
module dsc_mul_nin import dsc_pkg::*; #(
  parameter int SNG_WIDTH  = DSC_SNG_WIDTH,
  parameter int NUM_INPUTS = DSC_NUM_INPUTS,
  parameter int OUT_WIDTH  = NUM_INPUTS * SNG_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             en,
  input  logic [NUM_INPUTS*SNG_WIDTH-1:0]  in_vec,
  output logic [OUT_WIDTH-1:0]             z,
  output logic                             busy,
  output logic                             done
);

  localparam int CW = cnt_width(SNG_WIDTH, NUM_INPUTS);
  localparam int LW = CW - SNG_WIDTH;

  dsc_state_e state, state_nxt;

  logic [NUM_INPUTS-1:0][SNG_WIDTH-1:0] slot, ld_slot;
  logic [CW-1:0]                        cnt, cnt_inc, term;
  logic [NUM_INPUTS-1:0]                strm;
  logic                                 prod, adv, last;

`ifdef DSC_MUL_SORT_EN
  dsc_min_sort #(.W(SNG_WIDTH), .N(NUM_INPUTS)) u_sort (
    .in_vec (in_vec),
    .out_vec(ld_slot)
  );
`else
  assign ld_slot = in_vec;
`endif

  // One stream bit per digit: high while that digit is below its operand.
  for (genvar j = 0; j < NUM_INPUTS; j++) begin : g_strm
    assign strm[j] = cnt[j*SNG_WIDTH +: SNG_WIDTH] < slot[j];
  end

  assign prod    = &strm;
  assign adv     = (state == RUN) && en;
  assign cnt_inc = cnt + CW'(1);
  // Once the top digit reaches its operand, no later count can set the top
  // stream, so the run ends here.
  assign term    = {slot[NUM_INPUTS-1], {LW{1'b0}}};
  assign last    = adv && (cnt_inc == term);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic. LOAD looks at the incoming top operand because the
  // slots are not written until the end of LOAD.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    state_nxt = (ld_slot[NUM_INPUTS-1] != '0) ? RUN : DONE;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = start ? LOAD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded from the state.
  always_comb begin
    busy = (state == LOAD) || (state == RUN);
    done = (state == DONE);
  end

  // Datapath: latch operands and clear in LOAD, count and accumulate in RUN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot <= '0;
      cnt  <= '0;
      z    <= '0;
    end else if (state == LOAD) begin
      slot <= ld_slot;
      cnt  <= '0;
      z    <= '0;
    end else if (adv) begin
      cnt <= cnt_inc;
      z   <= z + OUT_WIDTH'(prod);
    end
  end

endmodule

// File: tb/tb_dsc_mul_nin.sv
// Bench for dsc_mul_nin with W=4, N=3. It runs a table of vectors and a few
// hand-written sequences: async reset mid-run and back-to-back starts.
module tb_dsc_mul_nin;

  localparam int W  = 4;
  localparam int N  = 3;
  localparam int OW = N * W;

  logic          clk   = 1'b0;
  logic          rst   = 1'b0;
  logic          start = 1'b0;
  logic          en    = 1'b0;
  logic [N*W-1:0] in_vec = '0;
  logic [OW-1:0] z;
  logic          busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [N*W-1:0] ops;
    bit             tgl;
    int unsigned    exp_z;
  } vec_t;

  typedef struct {
    int unsigned z;
    int          lat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  dsc_mul_nin #(.SNG_WIDTH(W), .NUM_INPUTS(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .en    (en),
    .in_vec(in_vec),
    .z     (z),
    .busy  (busy),
    .done  (done)
  );

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference latency: T is the top operand, or the minimum when sorting.
  function automatic int model_lat(input logic [N*W-1:0] ops, input bit tgl);
    int t, l;
    t = int'(ops[(N-1)*W +: W]);
`ifdef DSC_MUL_SORT_EN
    for (int k = 0; k < N; k++)
      if (int'(ops[k*W +: W]) < t) t = int'(ops[k*W +: W]);
`endif
    l = t << (W * (N - 1));
    if (l == 0) return 2;
    return tgl ? 1 + 2 * l : 2 + l;
  endfunction

  // Count cycles from c0 until done. Busy must stay high before done. With
  // poke set, pulse start while busy.
  task automatic wait_done(input int c0, input bit tgl, input bit poke,
                           output int lat, output bit bsy_ok);
    lat    = 0;
    bsy_ok = 1'b1;
    for (int c = c0; c <= 9000; c++) begin
      @(negedge clk);
      if (done) begin
        lat = c;
        break;
      end
      if (!busy) bsy_ok = 1'b0;
      en = tgl ? (c % 2 == 0) : 1'b1;
      if (poke) start = (c == 5);
    end
  endtask

  task automatic run_vec(input string nm, input logic [N*W-1:0] ops, input bit tgl,
                         input int unsigned ez);
    int   lat;
    bit   bok;
    exp_t e;
    @(negedge clk);
    in_vec = ops;
    start  = 1'b1;
    en     = 1'b1;
    sb.push_back('{z: ez, lat: model_lat(ops, tgl)});
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(1, tgl, tgl, lat, bok);
    e = sb.pop_front();
    chk({nm, "_z"}, z, e.z);
    chk({nm, "_lat"}, lat, e.lat);
    chk({nm, "_busy"}, bok, 1);
    @(negedge clk);
    chk({nm, "_pulse"}, {done, busy}, 0);
    en = 1'b1;
  endtask

  vec_t tbl[9];

  initial begin
    int   lat;
    bit   bok;
    exp_t e;

    // op2, op1, op0 from left to right
    tbl[0] = '{ops: {4'd7,  4'd5,  4'd3},  tgl: 1'b0, exp_z: 105};
    tbl[1] = '{ops: {4'd15, 4'd15, 4'd15}, tgl: 1'b0, exp_z: 3375};
    tbl[2] = '{ops: {4'd9,  4'd9,  4'd0},  tgl: 1'b0, exp_z: 0};
    tbl[3] = '{ops: {4'd0,  4'd9,  4'd9},  tgl: 1'b0, exp_z: 0};
    tbl[4] = '{ops: {4'd1,  4'd1,  4'd1},  tgl: 1'b0, exp_z: 1};
    tbl[5] = '{ops: {4'd2,  4'd1,  4'd15}, tgl: 1'b0, exp_z: 30};
    tbl[6] = '{ops: {4'd1,  4'd7,  4'd5},  tgl: 1'b1, exp_z: 35};
    tbl[7] = '{ops: {4'd4,  4'd15, 4'd2},  tgl: 1'b1, exp_z: 120};
    tbl[8] = '{ops: {4'd12, 4'd13, 4'd14}, tgl: 1'b0, exp_z: 2184};

    // Reset state, then idle with en high and start low.
    repeat (2) @(negedge clk);
    chk("reset_state", {z, busy, done}, 0);
    rst = 1'b1;
    en  = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_hold", {z, busy, done}, 0);

    foreach (tbl[i]) run_vec($sformatf("vec%0d", i), tbl[i].ops, tbl[i].tgl, tbl[i].exp_z);

    // Asynchronous reset in the middle of a run.
    @(negedge clk);
    in_vec = {4'd15, 4'd15, 4'd15};
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (100) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_z_nz", (z != 0), 1);
    #1 rst = 1'b0;
    #1;
    chk("rst_async", {z, busy, done}, 0);
    @(negedge clk);
    chk("rst_no_done", {busy, done}, 0);
    rst = 1'b1;
    run_vec("after_rst", {4'd1, 4'd3, 4'd2}, 1'b0, 6);

    // Back-to-back runs with start held high through DONE.
    @(negedge clk);
    in_vec = {4'd4, 4'd3, 4'd2};
    start  = 1'b1;
    en     = 1'b1;
    sb.push_back('{z: 24, lat: model_lat({4'd4, 4'd3, 4'd2}, 1'b0)});
    @(posedge clk);
    #1;
    wait_done(1, 1'b0, 1'b0, lat, bok);
    e = sb.pop_front();
    chk("b2b_a_z", z, e.z);
    chk("b2b_a_lat", lat, e.lat);
    in_vec = {4'd1, 4'd1, 4'd1};
    sb.push_back('{z: 1, lat: model_lat({4'd1, 4'd1, 4'd1}, 1'b0)});
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("b2b_load", {done, busy}, 2'b01);
    @(negedge clk);
    chk("b2b_z_clear", z, 0);
    wait_done(3, 1'b0, 1'b0, lat, bok);
    start = 1'b0;
    e = sb.pop_front();
    chk("b2b_b_z", z, e.z);
    chk("b2b_b_lat", lat, e.lat);
    @(negedge clk);
    chk("b2b_b_pulse", {done, busy}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
